// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and AXI encodings for the I/D cache bus arbiter.
package cache_bus_pkg;
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_e;

    localparam int REQ_D = 0;
    localparam int REQ_I = 1;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
endpackage

// File: rtl/cache_bus_arbiter_if.sv
// AXI master bus shared by both caches; master side is the arbiter.
interface cache_bus_arbiter_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     arid, awid, rid, bid;
    logic [ADDR_WIDTH-1:0]   araddr, awaddr;
    logic [7:0]              arlen, awlen;
    logic [2:0]              arsize, awsize, arprot, awprot;
    logic [1:0]              arburst, awburst, rresp, bresp;
    logic [3:0]              arcache, awcache;
    logic                    arlock, awlock;
    logic                    arvalid, arready, rvalid, rready, rlast;
    logic                    awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [DATA_WIDTH-1:0]   rdata, wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_bus_arbiter_rr.sv
// Two-way round-robin picker; rr_last remembers who won the last tie.
module rr_arbiter2
    import cache_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    logic rr_last;  // 1 = icache won last

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = rr_last ? 2'(1 << REQ_D) : 2'(1 << REQ_I);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_last <= 1'b1;
        else if (update)
            rr_last <= grant[REQ_I];
    end
endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one AXI master between icache and dcache: one line fill or writeback
// burst at a time, round-robin between the two caches.
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_store,
    input  logic [2*ADDR_WIDTH-1:0]       req_addr,
    input  logic [2*DATA_WIDTH*BEATS-1:0] req_wdata,
    output logic [1:0]                    req_ready,
    output logic [1:0]                    resp_valid,
    output logic [DATA_WIDTH*BEATS-1:0]   resp_data,
    output logic                          resp_err,
    cache_bus_arbiter_if.master           m_axi
);
    localparam int LINE       = DATA_WIDTH * BEATS;
    localparam int LINE_BYTES = LINE / 8;
    localparam int IW         = $clog2(BEATS);
    localparam int CW         = IW + 1;
    typedef logic [BEATS-1:0][DATA_WIDTH-1:0] line_t;

    state_e              state;
    logic                gid, err, tie, r_beat, r_bad, w_beat;
    logic                arvalid, awvalid, rready, wvalid, bready;
    logic [1:0]          grant;
    logic [ADDR_WIDTH-1:0] addr, axaddr;
    logic [ID_WIDTH-1:0] id;
    logic [CW-1:0]       beat_cnt;
    logic [IW-1:0]       idx;
    line_t               line, line_nxt;

    assign tie = (state == S_IDLE) && (req_valid == 2'b11);

    rr_arbiter2 u_rr (.clk(clk), .reset(reset), .req(req_valid), .update(tie), .grant(grant));

    assign req_ready = (state == S_IDLE) ? grant : 2'b00;
    assign id        = ID_WIDTH'(gid);
    assign idx       = beat_cnt[IW-1:0];
    assign axaddr    = addr & ~ADDR_WIDTH'(LINE_BYTES - 1);

    assign m_axi.arid    = id;
    assign m_axi.araddr  = axaddr;
    assign m_axi.arlen   = 8'(BEATS - 1);
    assign m_axi.arsize  = AXI_SIZE_8B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = '0;
    assign m_axi.arprot  = '0;
    assign m_axi.arvalid = arvalid;
    assign m_axi.rready  = rready;
    assign m_axi.awid    = id;
    assign m_axi.awaddr  = axaddr;
    assign m_axi.awlen   = 8'(BEATS - 1);
    assign m_axi.awsize  = AXI_SIZE_8B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = '0;
    assign m_axi.awprot  = '0;
    assign m_axi.awvalid = awvalid;
    assign m_axi.wdata   = line[idx];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = (beat_cnt == CW'(BEATS - 1));
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = bready;

    assign r_beat = (state == S_R) && m_axi.rvalid && rready;
    assign w_beat = (state == S_W) && wvalid && m_axi.wready;
    // Overlong bursts land at beat_cnt == BEATS: flagged and dropped.
    assign r_bad  = (m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rid != id) ||
                    (beat_cnt == CW'(BEATS)) ||
                    (m_axi.rlast && (beat_cnt != CW'(BEATS - 1)));

    always_comb begin
        line_nxt = line;
        if (r_beat && (beat_cnt < CW'(BEATS)))
            line_nxt[idx] = m_axi.rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            gid        <= 1'b0;
            addr       <= '0;
            line       <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
            arvalid    <= 1'b0;
            awvalid    <= 1'b0;
            rready     <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            line       <= line_nxt;
            resp_valid <= '0;
            case (state)
                S_IDLE: if (|grant) begin
                    gid  <= grant[REQ_I];
                    addr <= grant[REQ_I] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                         : req_addr[ADDR_WIDTH-1:0];
                    line <= grant[REQ_I] ? req_wdata[2*LINE-1:LINE] : req_wdata[LINE-1:0];
                    if (|(req_store & grant)) begin
                        awvalid <= 1'b1;
                        state   <= S_AW;
                    end else begin
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: if (m_axi.arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= S_R;
                end
                S_R: if (r_beat) begin
                    if (beat_cnt != CW'(BEATS))
                        beat_cnt <= beat_cnt + CW'(1);
                    if (r_bad)
                        err <= 1'b1;
                    if (m_axi.rlast) begin
                        rready     <= 1'b0;
                        resp_valid <= gid ? 2'b10 : 2'b01;
                        resp_err   <= err | r_bad;
                        resp_data  <= line_nxt;
                        state      <= S_RESP;
                    end
                end
                S_AW: if (m_axi.awready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    state   <= S_W;
                end
                S_W: if (w_beat) begin
                    beat_cnt <= beat_cnt + CW'(1);
                    if (m_axi.wlast) begin
                        wvalid <= 1'b0;
                        bready <= 1'b1;
                        state  <= S_B;
                    end
                end
                S_B: if (m_axi.bvalid) begin
                    bready     <= 1'b0;
                    resp_valid <= gid ? 2'b10 : 2'b01;
                    resp_err   <= err | (m_axi.bresp != AXI_RESP_OKAY) | (m_axi.bid != id);
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_err <= 1'b0;
                    err      <= 1'b0;
                    beat_cnt <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench: scripted AXI slave responses with hand-computed expectations.
module tb_cache_bus_arbiter;
    localparam int AW = 64, DW = 64, BEATS = 8, LINE = DW * BEATS, IDW = 13;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req_valid = '0, req_store = '0;
    logic [2*AW-1:0]   req_addr = '0;
    logic [2*LINE-1:0] req_wdata = '0;
    logic [1:0]        req_ready, resp_valid;
    logic [LINE-1:0]   resp_data, last_fill;
    logic              resp_err;
    int                n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    cache_bus_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    cache_bus_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .m_axi(axi)
    );

    task automatic chk(input string tag, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rid = '0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {req_ready, resp_valid, resp_err, axi.arvalid, axi.awvalid,
                  axi.wvalid, axi.rready, axi.bready}, '0);
        chk({tag, " resp_data"}, resp_data, '0);
    endtask

    // Fill: rresp error on beat eb (-1 none), rlast on beat lb, rdata = base + k.
    task automatic fill(input int g, input logic [63:0] a, input logic [63:0] base,
                        input int eb, input int lb, input logic exp_err, input logic chk_data);
        logic [LINE-1:0] exp_line = '0;
        logic [1:0]      oh = 2'(1 << g);
        @(negedge clk);
        chk("resp_valid one cycle", resp_valid, '0);
        req_valid[g] = 1'b1; req_store[g] = 1'b0; req_addr[g*AW +: AW] = a;
        #1 chk("fill grant", req_ready, oh);
        @(negedge clk);
        req_valid[g] = 1'b0;
        #1 chk("req_ready one cycle", req_ready, '0);
        chk("arvalid", axi.arvalid, 1'b1);
        chk("araddr", axi.araddr, a & ~64'h3f);
        chk("ar len/size/burst/id", {axi.arlen, axi.arsize, axi.arburst, axi.arid},
            {8'd7, 3'b011, 2'b01, IDW'(g)});
        for (int k = 0; k <= lb; k++) begin
            @(negedge clk);
            if (k == 0) chk("rready", axi.rready, 1'b1);
            axi.rvalid = 1'b1; axi.rdata = base + 64'(k); axi.rid = IDW'(g);
            axi.rresp = (k == eb) ? 2'b10 : 2'b00; axi.rlast = (k == lb);
            exp_line[k*DW +: DW] = base + 64'(k);
        end
        @(negedge clk);
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        chk("fill resp_valid", resp_valid, oh);
        chk("fill resp_err", resp_err, exp_err);
        chk("no grant in RESP", req_ready, '0);
        if (chk_data) begin
            chk("fill resp_data", resp_data, exp_line);
            last_fill = exp_line;
        end
    endtask

    // Writeback of wdata beat k = base + k; wready held low stall_n cycles at stall_beat.
    task automatic wb(input int g, input logic [63:0] a, input logic [63:0] base,
                      input int stall_beat, input int stall_n);
        logic [LINE-1:0] ln = '0;
        logic [1:0]      oh = 2'(1 << g);
        int              bk = 0, stalls = 0;
        for (int k = 0; k < BEATS; k++) ln[k*DW +: DW] = base + 64'(k);
        @(negedge clk);
        chk("resp_valid one cycle", resp_valid, '0);
        req_valid[g] = 1'b1; req_store[g] = 1'b1; req_addr[g*AW +: AW] = a;
        req_wdata[g*LINE +: LINE] = ln;
        #1 chk("wb grant", req_ready, oh);
        @(negedge clk);
        req_valid[g] = 1'b0; req_store[g] = 1'b0;
        chk("awvalid", axi.awvalid, 1'b1);
        chk("awaddr", axi.awaddr, a & ~64'h3f);
        chk("aw len/size/burst/id", {axi.awlen, axi.awsize, axi.awburst, axi.awid},
            {8'd7, 3'b011, 2'b01, IDW'(g)});
        chk("wvalid during AW", axi.wvalid, 1'b0);
        for (int c = 0; c < 20 && bk < BEATS; c++) begin
            @(negedge clk);
            axi.wready = !(bk == stall_beat && stalls < stall_n);
            chk("wvalid", axi.wvalid, 1'b1);
            chk("wdata", axi.wdata, base + 64'(bk));
            chk("wlast", axi.wlast, bk == BEATS - 1);
            if (axi.wready) bk++; else stalls++;
        end
        @(negedge clk);
        axi.wready = 1'b1;
        chk("bready", axi.bready, 1'b1);
        chk("wvalid after last", axi.wvalid, 1'b0);
        axi.bvalid = 1'b1; axi.bid = IDW'(g); axi.bresp = 2'b00;
        @(negedge clk);
        axi.bvalid = 1'b0;
        chk("wb resp_valid", resp_valid, oh);
        chk("wb resp_err", resp_err, 1'b0);
        chk("resp_data held", resp_data, last_fill);
    endtask

    initial begin
        slave_idle();
        last_fill = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b1;

        fill(0, 64'h1_0038, 64'h0, -1, 7, 1'b0, 1'b1);
        wb(1, 64'h2000, 64'hA0, 3, 2);
        fill(0, 64'h4_0040, 64'h100, 4, 7, 1'b1, 1'b0);
        fill(1, 64'h8_0000, 64'h200, -1, 7, 1'b0, 1'b1);
        fill(0, 64'h3000, 64'h300, -1, 5, 1'b1, 1'b0);

        // Both caches keep requesting: dcache, icache, dcache.
        req_valid = 2'b11;
        fill(0, 64'h5000, 64'h400, -1, 7, 1'b0, 1'b1);
        req_valid[0] = 1'b1;
        fill(1, 64'h6000, 64'h500, -1, 7, 1'b0, 1'b1);
        req_valid[1] = 1'b1;
        fill(0, 64'h7000, 64'h600, -1, 7, 1'b0, 1'b1);
        req_valid = 2'b00;

        // Abort a dcache fill at beat 3; rr state must return to its reset value.
        @(negedge clk);
        req_valid = 2'b01; req_addr[AW-1:0] = 64'h9000;
        #1 chk("pre-reset grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            axi.rvalid = 1'b1; axi.rdata = 64'(k); axi.rid = '0; axi.rlast = 1'b0;
        end
        #1 reset = 1'b0;
        #1 chk_quiet("mid-burst reset");
        @(negedge clk);
        slave_idle();
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("after reset release");
        req_valid = 2'b11;
        #1 chk("post-reset tie grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
